mgia_line_fetcher: RTL
======================

# mgia_line_fetcher

Wishbone read master that fills the MGIA scan-line buffer ahead of the display shifter. On each line-start pulse it streams one scan line of 16-bit framebuffer words from video memory and writes them, word by word, into the line buffer's store port. It tracks the framebuffer line pointer across the frame and reloads it at vertical sync. Bank selection, which half of the double buffer is being written, is external and driven by the same line-parity signal that steers the line buffer.

## Interface
- `WORDS_PER_LINE`, default 40: 16-bit words fetched per line (640 px at 1 bpp); legal range 1..64.
- `ADR_W`, default 23: width of the word address on the memory bus.
- `CLK_I` in 1: sole clock.
- `RST_I` in 1: reset, synchronous, active-high.
- `VSYNC_I` in 1: one-cycle pulse; requests a line-pointer reload from `FB_BASE_I`.
- `HSTART_I` in 1: one-cycle pulse; starts the fetch of the next line.
- `FB_BASE_I` in ADR_W: framebuffer word base address, sampled at reload.
- `M_CYC_O` out 1: bus cycle.
- `M_STB_O` out 1: bus strobe.
- `M_ADR_O` out ADR_W: word address.
- `M_DAT_I` in 16: read data.
- `M_ACK_I` in 1: transfer acknowledge.
- `S_ADR_O` out 6: line-buffer store address.
- `S_DAT_O` out 16: line-buffer store data.
- `S_WE_O` out 1: line-buffer store write strobe.
- `BUSY_O` out 1: high while a line fetch is in progress.
- `OVERRUN_O` out 1: one-cycle pulse when `HSTART_I` arrives while busy.

## Operation
- The block has two states, IDLE and FETCH.
- Registers: `line_ptr[ADR_W]`, `idx[6]` (words acknowledged), `reload_pend`.
- **IDLE**
  - `VSYNC_I` loads `line_ptr <= FB_BASE_I`.
  - `HSTART_I` loads `idx <= 0` and moves to FETCH.
  - If both arrive in the same cycle, the reload applies first and the fetch starts at `FB_BASE_I`.
- **FETCH**
  - `M_CYC_O`, `M_STB_O` and `BUSY_O` are held high continuously.
  - `M_ADR_O = line_ptr + idx`, registered.
  - On each cycle with `M_ACK_I`:
    - capture `M_DAT_I` into `S_DAT_O` and `idx` into `S_ADR_O`; pulse `S_WE_O` the following cycle;
    - increment `idx`; `M_ADR_O` advances on the same edge.
  - On the ACK where `idx == WORDS_PER_LINE-1`:
    - drop CYC/STB on that edge and return to IDLE;
    - update the pointer: `line_ptr <= reload_pend ? FB_BASE_I : line_ptr + WORDS_PER_LINE`;
    - clear `reload_pend`.
- **Events during FETCH**
  - `VSYNC_I` sets `reload_pend`; the current line completes unchanged.
  - `HSTART_I` is ignored and pulses `OVERRUN_O`. No fetch is queued.
- **Arithmetic**
  - Address adds are modulo 2^ADR_W; wrap is silent.
  - `S_ADR_O` carries `idx` in 6 bits, so index values never exceed 63.

## Timing
- **Reset:** all outputs are 0, state is IDLE, `line_ptr <= FB_BASE_I`, `reload_pend <= 0`.
- `RST_I` mid-fetch drops CYC/STB on the next edge. No further `S_WE_O` is issued, including for an ACK in the reset cycle.
- **Start:** `HSTART_I` at edge n gives CYC/STB/BUSY high from n+1.
- **Data path:** an ACK at edge k produces `S_WE_O`/`S_ADR_O`/`S_DAT_O` valid during cycle k+1, for exactly one cycle per ACK.
- **Throughput:** one word per cycle with zero-wait ACK, so a line takes `WORDS_PER_LINE` cycles plus 1 start cycle.
- **Completion:** `BUSY_O` falls the cycle after the last ACK. The final `S_WE_O` coincides with `BUSY_O` low.
- **Next line:** a new `HSTART_I` is accepted in that same cycle.
- **Bus protocol:** STB is never deasserted between words within a line. An ACK while CYC is low is ignored.

## Structure
- The shared MGIA package holds:
  - the default `WORDS_PER_LINE`;
  - the line-buffer address width (6);
  - the data width (16);
  - state encodings for IDLE/FETCH.
- Single flat module; no sub-module is warranted. The address adder and index counter are inline.

## Test plan
- **Reset fetch:** `FB_BASE_I=0x1000`, reset, `HSTART_I`, zero-wait ACK.
  - `M_ADR_O` runs 0x1000..0x1027.
  - 40 `S_WE_O` pulses with `S_ADR_O` 0..39 and data matching memory.
  - `BUSY_O` is high for 40 cycles.
- **Line advance:** a second `HSTART_I` after completion fetches 0x1028..0x104F.
- **Wait states:** ACK every 3rd cycle.
  - `M_ADR_O` stable between ACKs.
  - `S_WE_O` count is still 40, each pulse one cycle after its ACK.
- **VSYNC mid-fetch:** `VSYNC_I` with `FB_BASE_I=0x2000` at word 10.
  - The current line completes at 0x1000-based addresses.
  - The next line starts at 0x2000.
- **Overrun:** `HSTART_I` during FETCH.
  - `OVERRUN_O` pulses once; the fetch is unaffected.
  - No extra fetch follows.
- **Reset mid-fetch:** `RST_I` at word 20.
  - CYC/STB/BUSY are low next cycle; no further `S_WE_O`.
  - A subsequent `HSTART_I` fetches from `FB_BASE_I`.

Source files
------------

// File: rtl/mgia_line_fetcher_pkg.sv
// Shared MGIA definitions for the scan-line fetcher.
// Contents: default words per line, line-buffer address width,
// framebuffer data width and the fetcher state encoding.
package mgia_line_fetcher_pkg;

  // 640 px at 1 bpp, fetched as 16-bit words
  localparam int unsigned WordsPerLineDef = 40;
  localparam int unsigned LineAdrW        = 6;
  localparam int unsigned DataW           = 16;

  typedef enum logic {
    StIdle  = 1'b0,
    StFetch = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/mgia_line_fetcher_if.sv
// Bus bundle between the line fetcher, video memory (Wishbone read side)
// and the line buffer store port.
//   M_CYC_O/M_STB_O/M_ADR_O : master request towards memory
//   M_DAT_I/M_ACK_I         : memory response
//   S_ADR_O/S_DAT_O/S_WE_O  : line-buffer store port
interface mgia_line_fetcher_if #(
  parameter int unsigned ADR_W = 23
);
  logic                                      M_CYC_O;
  logic                                      M_STB_O;
  logic [ADR_W-1:0]                          M_ADR_O;
  logic [mgia_line_fetcher_pkg::DataW-1:0]    M_DAT_I;
  logic                                      M_ACK_I;
  logic [mgia_line_fetcher_pkg::LineAdrW-1:0] S_ADR_O;
  logic [mgia_line_fetcher_pkg::DataW-1:0]    S_DAT_O;
  logic                                      S_WE_O;

  modport master (
    output M_CYC_O, M_STB_O, M_ADR_O, S_ADR_O, S_DAT_O, S_WE_O,
    input  M_DAT_I, M_ACK_I
  );

  modport slave (
    input  M_CYC_O, M_STB_O, M_ADR_O, S_ADR_O, S_DAT_O, S_WE_O,
    output M_DAT_I, M_ACK_I
  );
endinterface

// File: rtl/mgia_line_fetcher.sv
// Wishbone read master that streams one scan line of framebuffer words into
// the line buffer on every line-start pulse, tracking the line pointer across
// the frame and reloading it at vertical sync.
//   CLK_I, RST_I  : clock, synchronous active-high reset
//   VSYNC_I       : request line-pointer reload from FB_BASE_I
//   HSTART_I      : start fetching the next line
//   FB_BASE_I     : framebuffer word base address
//   BUSY_O        : line fetch in progress
//   OVERRUN_O     : pulse when HSTART_I arrives while busy
//   bus           : memory master + line-buffer store port
module mgia_line_fetcher
  import mgia_line_fetcher_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = WordsPerLineDef,
  parameter int unsigned ADR_W          = 23
) (
  input  logic                       CLK_I,
  input  logic                       RST_I,
  input  logic                       VSYNC_I,
  input  logic                       HSTART_I,
  input  logic [ADR_W-1:0]           FB_BASE_I,
  output logic                       BUSY_O,
  output logic                       OVERRUN_O,
  mgia_line_fetcher_if.master        bus
);

  localparam logic [LineAdrW-1:0] LastIdx = LineAdrW'(WORDS_PER_LINE - 1);

  fetch_state_e         state_q, state_d;
  logic [ADR_W-1:0]     line_ptr_q, line_ptr_d;
  logic [LineAdrW-1:0]  idx_q, idx_d;
  logic                 reload_pend_q, reload_pend_d;
  logic [ADR_W-1:0]     adr_q, adr_d;
  logic                 s_we_q, s_we_d;
  logic [LineAdrW-1:0]  s_adr_q, s_adr_d;
  logic [DataW-1:0]     s_dat_q, s_dat_d;
  logic                 overrun_q, overrun_d;

  always_comb begin
    state_d       = state_q;
    line_ptr_d    = line_ptr_q;
    idx_d         = idx_q;
    reload_pend_d = reload_pend_q;
    adr_d         = adr_q;
    s_we_d        = 1'b0;
    s_adr_d       = s_adr_q;
    s_dat_d       = s_dat_q;
    overrun_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (VSYNC_I) begin
          line_ptr_d = FB_BASE_I;
        end
        // line_ptr_d already reflects a same-cycle reload
        if (HSTART_I) begin
          idx_d   = '0;
          adr_d   = line_ptr_d;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (VSYNC_I) begin
          reload_pend_d = 1'b1;
        end
        if (HSTART_I) begin
          overrun_d = 1'b1;
        end
        if (bus.M_ACK_I) begin
          s_we_d  = 1'b1;
          s_adr_d = idx_q;
          s_dat_d = bus.M_DAT_I;
          idx_d   = idx_q + 1'b1;
          // adr_q always equals line_ptr_q + idx_q while fetching
          adr_d   = adr_q + ADR_W'(1);
          if (idx_q == LastIdx) begin
            state_d       = StIdle;
            line_ptr_d    = (reload_pend_q || VSYNC_I) ? FB_BASE_I
                                                       : line_ptr_q + ADR_W'(WORDS_PER_LINE);
            reload_pend_d = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q       <= StIdle;
      line_ptr_q    <= FB_BASE_I;
      idx_q         <= '0;
      reload_pend_q <= 1'b0;
      adr_q         <= '0;
      s_we_q        <= 1'b0;
      s_adr_q       <= '0;
      s_dat_q       <= '0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_ptr_q    <= line_ptr_d;
      idx_q         <= idx_d;
      reload_pend_q <= reload_pend_d;
      adr_q         <= adr_d;
      s_we_q        <= s_we_d;
      s_adr_q       <= s_adr_d;
      s_dat_q       <= s_dat_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.M_CYC_O = (state_q == StFetch);
  assign bus.M_STB_O = (state_q == StFetch);
  assign bus.M_ADR_O = adr_q;
  assign bus.S_WE_O  = s_we_q;
  assign bus.S_ADR_O = s_adr_q;
  assign bus.S_DAT_O = s_dat_q;
  assign BUSY_O      = (state_q == StFetch);
  assign OVERRUN_O   = overrun_q;

endmodule
